axi_read_slave: RTL and testbench

AXI_READ_SLAVE -- requirements
Module: axi_read_slave

---
 rtl/axi_read_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_read_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_slave.sv
// AXI4 read-only slave in front of a single-port 256-bit memory with a
// one-cycle read latency. One burst is outstanding at a time. Beats pass
// through a 2-entry output FIFO; an entry whose memory read is still landing
// presents mem_rd_data directly, so the first beat appears two cycles after
// the AR handshake.
//
// Handshake rule on both AXI channels: a transfer happens on a rising edge
// where valid and ready are both 1; the sender holds payload stable while
// valid=1 and ready=0, and valid never depends combinationally on ready.
module axi_read_slave #(
    parameter int MEM_WORDS = 1024,
    parameter int MEM_AW    = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // AR channel
    input  logic [6:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    // R channel
    output logic [6:0]        rid,
    output logic [255:0]      rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // memory read port
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [255:0]      mem_rd_data,
    // FSM state for observation
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Burst context
    state_t      state_q, state_d;
    logic [6:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic        illegal_q, illegal_d;
    logic [26:0] cur_q, cur_d;      // full word index (araddr >> 5), untruncated
    logic [7:0]  cnt_q, cnt_d;      // index of the next beat to issue

    // Output FIFO (2 entries); land marks an entry whose memory data arrives this cycle
    logic [255:0] data_q [2];
    logic [255:0] data_d [2];
    logic [1:0]   resp_q [2];
    logic [1:0]   resp_d [2];
    logic         last_q [2];
    logic         last_d [2];
    logic         land_q [2];
    logic         land_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    logic        issue;
    logic        pop;
    logic        beat_oob;
    logic [26:0] wrap_mask;
    logic [26:0] next_addr;
    logic        wrap_len_ok;

    // Next-state, FIFO bookkeeping and all combinational outputs
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        burst_d   = burst_q;
        illegal_d = illegal_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        resp_d    = resp_q;
        last_d    = last_q;
        land_d    = land_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        dbg_state = state_q;
        arready   = (state_q == IDLE) && !i_reset;

        // R outputs come from the FIFO head; zero whenever nothing is presented
        rvalid = (count_q != 2'd0);
        rid    = '0;
        rdata  = '0;
        rresp  = '0;
        rlast  = 1'b0;
        if (rvalid) begin
            rid   = id_q;
            rdata = land_q[rd_ptr_q] ? mem_rd_data : data_q[rd_ptr_q];
            rresp = resp_q[rd_ptr_q];
            rlast = last_q[rd_ptr_q];
        end
        pop = rvalid && rready;

        // A beat is issued when the FIFO (including landing reads) has room
        issue       = (state_q == DATA) && (count_q < 2'd2);
        beat_oob    = (cur_q >= 27'(MEM_WORDS));
        mem_rd_en   = issue && !illegal_q && !beat_oob;
        mem_rd_addr = mem_rd_en ? cur_q[MEM_AW-1:0] : '0;

        // Per-beat address step
        wrap_mask = {19'd0, len_q};
        case (burst_q)
            2'b00:   next_addr = cur_q;
            2'b10:   next_addr = (cur_q & ~wrap_mask) | ((cur_q + 27'd1) & wrap_mask);
            default: next_addr = cur_q + 27'd1;
        endcase

        // Landing reads are captured so the data stays stable if stalled
        for (int i = 0; i < 2; i++) begin
            if (land_q[i]) begin
                data_d[i] = mem_rd_data;
                land_d[i] = 1'b0;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (issue) begin
            data_d[wr_ptr_q] = '0;
            land_d[wr_ptr_q] = mem_rd_en;
            last_d[wr_ptr_q] = (cnt_q == len_q);
            if (illegal_q) begin
                resp_d[wr_ptr_q] = RESP_SLVERR;
            end else if (beat_oob) begin
                resp_d[wr_ptr_q] = RESP_DECERR;
            end else begin
                resp_d[wr_ptr_q] = RESP_OKAY;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        count_d = count_q + {1'b0, issue} - {1'b0, pop};

        wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) ||
                      (arlen == 8'd7) || (arlen == 8'd15);

        case (state_q)
            IDLE: begin
                if (arvalid && arready) begin
                    id_d      = arid;
                    len_d     = arlen;
                    burst_d   = arburst;
                    cur_d     = araddr[31:5];
                    cnt_d     = 8'd0;
                    illegal_d = (arsize != 3'd5) || (arburst == 2'b11) ||
                                ((arburst == 2'b10) && !wrap_len_ok);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (issue) begin
                    cur_d = next_addr;
                    if (cnt_q == len_q) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (pop && rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset empties the FIFO and drops in-flight reads
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            illegal_q <= 1'b0;
            cur_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '{default: '0};
            resp_q    <= '{default: '0};
            last_q    <= '{default: 1'b0};
            land_q    <= '{default: 1'b0};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            illegal_q <= illegal_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            last_q    <= last_d;
            land_q    <= land_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: a behavioural one-cycle-latency memory,
// an AR driver, and a monitor that checks every presented R beat against a
// queue of hand-listed expected beats.
module tb_axi_read_slave;
  localparam int MEM_WORDS = 1024;
  localparam int MEM_AW    = 10;
  localparam int EW        = 266;  // {rid, rdata, rresp, rlast}

  logic              clk;
  logic              i_reset;
  logic [6:0]        arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [6:0]        rid;
  logic [255:0]      rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic [255:0]      mem_rd_data;
  logic [1:0]        dbg_state;

  axi_read_slave #(.MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [255:0] mem [MEM_WORDS];
  int           mem_cnt;

  function automatic logic [255:0] mem_word(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(i);
    return {4{w, ~w}};
  endfunction

  initial begin
    mem_rd_data = '0;
    mem_cnt = 0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = mem_word(i);
  end

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      mem_cnt = mem_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [6:0] id, input int idx, input logic [1:0] resp,
                           input logic last);
    logic [255:0] d;
    d = (resp == 2'b00) ? mem_word(idx) : 256'd0;
    exp_q.push_back({id, d, resp, last});
  endtask

  // Monitor: every presented beat must match the queue head, also while stalled
  always @(negedge clk) begin
    if (!i_reset && rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got rid=%h rresp=%b rlast=%b with nothing expected",
                 rid, rresp, rlast);
      end else begin
        chk("r_beat", {rid, rdata, rresp, rlast}, exp_q[0]);
        if (rready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_ar(input logic [6:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    arvalid = 1'b0;
    chk("ar_handshake", EW'(done), EW'(1));
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 700) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    chk(name, EW'(exp_q.size()), EW'(0));
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int k;
    i_reset = 1'b1; rready = 1'b0; arvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        EW'({arready, rvalid, rlast, rid, rdata, rresp, mem_rd_en, mem_rd_addr}), EW'(0));
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    chk("arready_after_reset", EW'(arready), EW'(1));
    @(posedge clk); #1;

    // INCR words 0..5, back-to-back, first rvalid at handshake +2
    rready = 1'b1;
    for (int i = 0; i < 6; i++) push_beat(7'h12, i, 2'b00, i == 5);
    send_ar(7'h12, 32'h0, 8'd5, 3'd5, 2'b01);
    @(negedge clk);
    chk("t1_cycle1_rd_en_no_rvalid", EW'({mem_rd_en, rvalid}), EW'(2'b10));
    @(negedge clk);
    chk("t1_first_rvalid", EW'(rvalid), EW'(1));
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("t1_back_to_back", EW'(rvalid), EW'(1));
    end
    wait_drain("t1_drain");

    // WRAP from word 3 of a 4-word block
    push_beat(7'h05, 3, 2'b00, 1'b0);
    push_beat(7'h05, 0, 2'b00, 1'b0);
    push_beat(7'h05, 1, 2'b00, 1'b0);
    push_beat(7'h05, 2, 2'b00, 1'b1);
    send_ar(7'h05, 32'h60, 8'd3, 3'd5, 2'b10);
    wait_drain("t2_drain");

    // INCR words 8..11 with rready pattern 1,0,0,1,0,0,...
    for (int i = 8; i < 12; i++) push_beat(7'h21, i, 2'b00, i == 11);
    send_ar(7'h21, 32'h100, 8'd3, 3'd5, 2'b01);
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      rready = (k % 3 == 0);
      @(posedge clk); #1;
      k++;
    end
    rready = 1'b1;
    wait_drain("t3_drain");

    // illegal requests: bad size, WRAP length 3, reserved burst
    mem_cnt = 0;
    push_beat(7'h33, 0, 2'b10, 1'b0);
    push_beat(7'h33, 0, 2'b10, 1'b1);
    send_ar(7'h33, 32'h0, 8'd1, 3'd4, 2'b01);
    wait_drain("t4_size_drain");
    for (int i = 0; i < 3; i++) push_beat(7'h34, 0, 2'b10, i == 2);
    send_ar(7'h34, 32'h40, 8'd2, 3'd5, 2'b10);
    wait_drain("t4_wraplen_drain");
    push_beat(7'h35, 0, 2'b10, 1'b1);
    send_ar(7'h35, 32'h20, 8'd0, 3'd5, 2'b11);
    wait_drain("t4_burst11_drain");
    chk("t4_no_mem_reads", EW'(mem_cnt), EW'(0));

    // last word in range then one past the end
    push_beat(7'h44, MEM_WORDS - 1, 2'b00, 1'b0);
    push_beat(7'h44, 0, 2'b11, 1'b1);
    send_ar(7'h44, 32'((MEM_WORDS - 1) * 32), 8'd1, 3'd5, 2'b01);
    wait_drain("t5_drain");

    // reset while beat 2 of an 8-beat burst is presented
    for (int i = 16; i < 24; i++) push_beat(7'h55, i, 2'b00, i == 23);
    start = pop_cnt;
    send_ar(7'h55, 32'h200, 8'd7, 3'd5, 2'b01);
    k = 0;
    while (pop_cnt < start + 2 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t6_two_beats_before_reset", EW'(pop_cnt - start), EW'(2));
    @(posedge clk); #1;
    i_reset = 1'b1;
    rready = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    rready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rvalid_after_reset", EW'(rvalid), EW'(0));
    chk("t6_arready_after_reset", EW'(arready), EW'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_more_beats", EW'(rvalid), EW'(0));
    end
    @(posedge clk); #1;

    // single-beat request after the reset
    push_beat(7'h7F, 2, 2'b00, 1'b1);
    send_ar(7'h7F, 32'h5F, 8'd0, 3'd5, 2'b01);
    wait_drain("t7_drain");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
